// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Multi-precision add/subtract engine built around a single 4-bit adder
// slice. The slice is used once per clock, starting with the least
// significant nibble. A registered carry links consecutive nibbles. A
// start/busy/done handshake frames each operation.
//
// Subtraction is done as a + ~b + ~c_in. Operand B and the incoming
// carry are inverted when the operation is accepted, so the slice only
// ever adds.
//
// Parameters
//   WIDTH  operand/result width in bits (multiple of 4, at least 8)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only while idle
//   sub    in   0 = add, 1 = subtract (latched at accept)
//   a, b   in   WIDTH-bit operands (latched at accept)
//   c_in   in   carry-in (add) / borrow-in (subtract), latched at accept
//   busy   out  high while nibbles are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  WIDTH-bit registered result
//   c_out  out  final carry; for subtract 1 means no borrow
//   ovf    out  two's-complement signed overflow
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Encoding chosen so that busy and done are each a single state flop bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   shift_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   sum_r;
  logic               c_out_r;
  logic               ovf_r;

  logic [4:0]         slice_s;
  logic [WIDTH-1:0]   shift_next_s;
  logic               c3_s;
  logic               idx_last_s;
  logic               accept_s;
  logic               last_s;
  logic               busy_s;
  logic               done_s;

  // One pass of the shared 4-bit full-adder slice; bit 4 is the carry out.
  function automatic logic [4:0] slice_add(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  assign slice_s      = slice_add(opa_r[3:0], opb_r[3:0], carry_r);
  // The new nibble enters at the top. After NIBBLES passes the word is in order.
  assign shift_next_s = {slice_s[3:0], shift_r[WIDTH-1:4]};
  // Carry into the sign bit of the last slice, recovered from its sum bit.
  assign c3_s         = opa_r[3] ^ opb_r[3] ^ slice_s[3];
  assign idx_last_s   = (idx_r == IDX_W'(NIBBLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start is only looked at in IDLE and is never queued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output and control decode from the current state.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = start;
      ST_RUN: begin
        busy_s = 1'b1;
        last_s = idx_last_s;
      end
      ST_DONE: done_s = 1'b1;
      default: begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // Operand capture, nibble-serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      shift_r <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      opa_r   <= a;
      opb_r   <= b ^ {WIDTH{sub}};
      carry_r <= c_in ^ sub;
      idx_r   <= {IDX_W{1'b0}};
    end else if (busy_s) begin
      shift_r <= shift_next_s;
      opa_r   <= {4'b0000, opa_r[WIDTH-1:4]};
      opb_r   <= {4'b0000, opb_r[WIDTH-1:4]};
      carry_r <= slice_s[4];
      idx_r   <= idx_r + IDX_W'(1);
      // Results are published only at completion, so no partial word is visible.
      if (last_s) begin
        sum_r   <= shift_next_s;
        c_out_r <= slice_s[4];
        ovf_r   <= c3_s ^ slice_s[4];
      end
    end
  end

  assign busy  = busy_s;
  assign done  = done_s;
  assign sum   = sum_r;
  assign c_out = c_out_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH=16 and WIDTH=8.
// Stimulus tasks push expected results from an arithmetic reference model
// into per-instance queues. Independent monitors pop and compare on done.
module tb_nibble_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic        sub, cin;
  logic [15:0] a, b;
  logic        busy16, done16, c16, ovf16;
  logic [15:0] sum16;
  logic        busy8, done8, c8, ovf8;
  logic [7:0]  sum8;

  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a), .b(b),
    .c_in(cin), .busy(busy16), .done(done16), .sum(sum16), .c_out(c16),
    .ovf(ovf16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .c_in(cin), .busy(busy8), .done(done8), .sum(sum8), .c_out(c8),
    .ovf(ovf8)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int w, input logic [15:0] ta,
                                 input logic [15:0] tb, input logic ts,
                                 input logic tc);
    longint m, ua, ub, sa, sb, ci, r, sr;
    exp_t e;
    m  = 64'sd1 <<< w;
    ua = longint'(ta) & (m - 1);
    ub = longint'(tb) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = tc ? 64'sd1 : 64'sd0;
    if (ts) begin
      r    = ua - ub - ci;
      e.co = (ua >= ub + ci);
      sr   = sa - sb - ci;
    end else begin
      r    = ua + ub + ci;
      e.co = (r >= m);
      sr   = sa + sb + ci;
    end
    e.sum = 16'(r & (m - 1));
    e.ov  = (sr >= m / 2) || (sr < -(m / 2));
    return e;
  endfunction

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done w=16 sum=%h", sum16);
      end else begin
        e = q16.pop_front();
        if (sum16 !== e.sum || c16 !== e.co || ovf16 !== e.ov) begin
          errors++;
          $display("FAIL result w=16 got sum=%h c_out=%b ovf=%b required sum=%h c_out=%b ovf=%b",
                   sum16, c16, ovf16, e.sum, e.co, e.ov);
        end
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done w=8 sum=%h", sum8);
      end else begin
        e = q8.pop_front();
        if (sum8 !== e.sum[7:0] || c8 !== e.co || ovf8 !== e.ov) begin
          errors++;
          $display("FAIL result w=8 got sum=%h c_out=%b ovf=%b required sum=%h c_out=%b ovf=%b",
                   sum8, c8, ovf8, e.sum[7:0], e.co, e.ov);
        end
      end
    end
  end

  // Wait until the selected instance is idle; bounded.
  task automatic wait_idle(input int w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w == 8 ? !(busy8 | done8) : !(busy16 | done16)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_wait w=%0d still busy after 50 cycles, required idle", w);
    end
  endtask

  // Issue one operation and check the handshake timing.
  task automatic do_op(input int w, input logic [15:0] ta, input logic [15:0] tb,
                       input logic ts, input logic tc, input bit disturb);
    bit ok;
    int n, bc, nib;
    nib = w / 4;
    wait_idle(w, ok);
    if (!ok) return;
    a = ta; b = tb; sub = ts; cin = tc;
    if (w == 8) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    checks++;
    if (!(w == 8 ? busy8 : busy16)) begin
      errors++;
      $display("FAIL accept w=%0d busy=0 required 1", w);
      return;
    end
    if (w == 8) q8.push_back(model(w, ta, tb, ts, tc));
    else        q16.push_back(model(w, ta, tb, ts, tc));
    bc = 1; n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (disturb && i == 1) begin
        if (w == 8) start8 = 1'b1; else start16 = 1'b1;
        a = ~ta; b = 16'($urandom); sub = ~ts; cin = ~tc;
      end
      if (disturb && i == 2) begin
        start8 = 1'b0; start16 = 1'b0;
      end
      @(posedge clk); #1;
      if (w == 8 ? done8 : done16) begin
        n = i;
        break;
      end
      if (w == 8 ? busy8 : busy16) bc++;
    end
    checks++;
    if (n != nib) begin
      errors++;
      $display("FAIL latency w=%0d edges=%0d required %0d", w, n, nib);
    end
    checks++;
    if (bc != nib) begin
      errors++;
      $display("FAIL busy_cycles w=%0d got %0d required %0d", w, bc, nib);
    end
    if (disturb) begin
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ((w == 8 ? busy8 : busy16) !== 1'b0) begin
        errors++;
        $display("FAIL no_second_op w=%0d busy=1 required 0", w);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, last, prev, dn;
    rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = 16'h0000; b = 16'h0000;
    #2;
    checks++;
    if ({busy16, done16, sum16, c16, ovf16} !== 19'd0) begin
      errors++;
      $display("FAIL reset16 got busy=%b done=%b sum=%h c=%b ovf=%b required all 0",
               busy16, done16, sum16, c16, ovf16);
    end
    checks++;
    if ({busy8, done8, sum8, c8, ovf8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b sum=%h c=%b ovf=%b required all 0",
               busy8, done8, sum8, c8, ovf8);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    do_op(16, 16'h1234, 16'h0FCD, 1'b0, 1'b1, 1'b0);
    do_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    do_op(16, 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0);
    do_op(16, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an operation, right after a result with c_out=1 and ovf=1
    wait_idle(16, ok);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy16, done16, sum16, c16, ovf16} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b sum=%h c=%b ovf=%b required all 0",
               busy16, done16, sum16, c16, ovf16);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done16) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL done_after_reset got %0d pulses required 0", dn);
    end
    do_op(16, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    // start pulsed and operands changed while busy
    do_op(16, 16'hA5C3, 16'h3C5A, 1'b0, 1'b1, 1'b1);
    do_op(16, 16'h4321, 16'h9876, 1'b1, 1'b0, 1'b1);

    // start held high: back-to-back operations every NIBBLES+2 cycles
    wait_idle(16, ok);
    a = 16'h0F0F; b = 16'h00F1; sub = 1'b0; cin = 1'b1;
    for (int i = 0; i < 3; i++) q16.push_back(model(16, a, b, sub, cin));
    start16 = 1'b1;
    cnt = 0; last = -1; prev = 0;
    for (int cyc = 0; cyc < 40 && cnt < 3; cyc++) begin
      @(posedge clk); #1;
      if (done16) begin
        checks++;
        if (prev != 0) begin
          errors++;
          $display("FAIL done_width done high on consecutive cycles at cycle %0d, required 1-cycle pulse", cyc);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles required 6", cyc - last);
          end
        end
        last = cyc;
        cnt++;
        if (cnt == 3) start16 = 1'b0;
      end
      prev = done16 ? 1 : 0;
    end
    @(posedge clk); #1;
    checks++;
    if (cnt != 3 || done16 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got %0d pulses (done now %b) required 3 and done 0", cnt, done16);
    end

    // 8-bit instance
    do_op(8, 16'h00D9, 16'h0093, 1'b0, 1'b1, 1'b0);
    do_op(8, 16'h0080, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Random sweep: 400 vectors at WIDTH=16, 100 at WIDTH=8
    for (int i = 0; i < 400; i++)
      do_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 100; i++)
      do_op(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q16.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL pending_results got q16=%0d q8=%0d required 0 0", q16.size(), q8.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
